// File: rtl/vault_work_dispatcher.sv
// Host-side job dispatcher for the vault mining core: loads headers into the core,
// filters golden_nonce and returns tagged FOUND / TIMEOUT / STALE results.
module vault_work_dispatcher #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int SETTLE_CYCLES  = 4,
   parameter bit PREEMPT        = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [639:0] job_header,
   input  logic [7:0]   job_id,
   output logic [639:0] work_package,
   input  logic [31:0]  golden_nonce,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [31:0]  res_nonce,
   output logic [7:0]   res_job_id,
   output logic [1:0]   res_status,
   output logic         busy,
   output logic [15:0]  shares_found,
   output logic [1:0]   dbg_state
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_MINE   = 2'd2;
   localparam logic [1:0] S_REPORT = 2'd3;

   localparam logic [1:0] ST_FOUND   = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_STALE   = 2'b11;

   // Timer may step one past the deadline when a FOUND lands on the last cycle.
   localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   logic [1:0]    state_q, state_d;
   logic [639:0]  work_q, work_d;
   logic [7:0]    cur_id_q, cur_id_d;
   logic          pend_valid_q, pend_valid_d;
   logic [639:0]  pend_header_q, pend_header_d;
   logic [7:0]    pend_id_q, pend_id_d;
   logic [31:0]   last_nonce_q, last_nonce_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [SW-1:0] settle_q, settle_d;
   logic          res_valid_q, res_valid_d;
   logic [31:0]   res_nonce_q, res_nonce_d;
   logic [7:0]    res_id_q, res_id_d;
   logic [1:0]    res_status_q, res_status_d;
   logic [15:0]   shares_q, shares_d;

   logic job_ready_c;
   logic job_fire;
   logic res_fire;
   logic nonce_new;

   // Handshakes: a transfer happens on a rising edge where valid && ready; the
   // offering side holds valid and its payload stable until that edge.
   assign job_ready_c = (state_q == S_IDLE) ? 1'b1 : (PREEMPT ? ~pend_valid_q : 1'b0);
   assign job_fire    = job_valid & job_ready_c;
   assign res_fire    = res_valid_q & res_ready;
   assign nonce_new   = (golden_nonce != 32'd0) && (golden_nonce != last_nonce_q);

   always_comb begin
      state_d       = state_q;
      work_d        = work_q;
      cur_id_d      = cur_id_q;
      pend_valid_d  = pend_valid_q;
      pend_header_d = pend_header_q;
      pend_id_d     = pend_id_q;
      last_nonce_d  = last_nonce_q;
      timer_d       = timer_q;
      settle_d      = settle_q;
      res_valid_d   = res_valid_q;
      res_nonce_d   = res_nonce_q;
      res_id_d      = res_id_q;
      res_status_d  = res_status_q;
      shares_d      = shares_q;

      case (state_q)
         S_IDLE: begin
            if (job_fire) begin
               work_d       = job_header;
               cur_id_d     = job_id;
               last_nonce_d = 32'd0;
               timer_d      = '0;
               settle_d     = '0;
               state_d      = S_SETTLE;
            end
         end
         S_SETTLE, S_MINE: begin
            if (state_q == S_SETTLE) settle_d = settle_q + 1'b1;
            else                     timer_d  = timer_q + 1'b1;
            if (PREEMPT && job_fire) begin
               pend_valid_d  = 1'b1;
               pend_header_d = job_header;
               pend_id_d     = job_id;
               res_valid_d   = 1'b1;
               res_status_d  = ST_STALE;
               res_nonce_d   = 32'd0;
               res_id_d      = cur_id_q;
               state_d       = S_REPORT;
            end else if (state_q == S_SETTLE) begin
               if (settle_q >= SETTLE_LAST) state_d = S_MINE;
            end else if (nonce_new) begin
               res_valid_d  = 1'b1;
               res_status_d = ST_FOUND;
               res_nonce_d  = golden_nonce;
               res_id_d     = cur_id_q;
               last_nonce_d = golden_nonce;
               shares_d     = (shares_q == 16'hFFFF) ? shares_q : shares_q + 16'd1;
               state_d      = S_REPORT;
            end else if (timer_q >= TIMER_LAST) begin
               res_valid_d  = 1'b1;
               res_status_d = ST_TIMEOUT;
               res_nonce_d  = 32'd0;
               res_id_d     = cur_id_q;
               state_d      = S_REPORT;
            end
         end
         default: begin
            if (job_fire) begin
               pend_valid_d  = 1'b1;
               pend_header_d = job_header;
               pend_id_d     = job_id;
            end
            if (res_fire) begin
               res_valid_d = 1'b0;
               if (pend_valid_q || job_fire) begin
                  work_d       = pend_valid_q ? pend_header_q : job_header;
                  cur_id_d     = pend_valid_q ? pend_id_q : job_id;
                  pend_valid_d = 1'b0;
                  last_nonce_d = 32'd0;
                  timer_d      = '0;
                  settle_d     = '0;
                  state_d      = S_SETTLE;
               end else if (res_status_q == ST_FOUND) begin
                  state_d = S_MINE;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         work_q        <= '0;
         cur_id_q      <= '0;
         pend_valid_q  <= 1'b0;
         pend_header_q <= '0;
         pend_id_q     <= '0;
         last_nonce_q  <= '0;
         timer_q       <= '0;
         settle_q      <= '0;
         res_valid_q   <= 1'b0;
         res_nonce_q   <= '0;
         res_id_q      <= '0;
         res_status_q  <= '0;
         shares_q      <= '0;
      end else begin
         state_q       <= state_d;
         work_q        <= work_d;
         cur_id_q      <= cur_id_d;
         pend_valid_q  <= pend_valid_d;
         pend_header_q <= pend_header_d;
         pend_id_q     <= pend_id_d;
         last_nonce_q  <= last_nonce_d;
         timer_q       <= timer_d;
         settle_q      <= settle_d;
         res_valid_q   <= res_valid_d;
         res_nonce_q   <= res_nonce_d;
         res_id_q      <= res_id_d;
         res_status_q  <= res_status_d;
         shares_q      <= shares_d;
      end
   end

   assign job_ready    = job_ready_c;
   assign work_package = work_q;
   assign res_valid    = res_valid_q;
   assign res_nonce    = res_nonce_q;
   assign res_job_id   = res_id_q;
   assign res_status   = res_status_q;
   assign busy         = (state_q != S_IDLE);
   assign shares_found = shares_q;
   assign dbg_state    = state_q;

endmodule
